daa_rx_deserializer: RTL and testbench

DAA_RX_DESERIALIZER -- requirements
Module: daa_rx_deserializer

---
 rtl/daa_rx_deserializer.sv | 170 +++++++++++++++++
 tb/tb_daa_rx_deserializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/daa_rx_deserializer.sv
// DAA receive deserializer: samples SDA at SCL rising edges into a bit-indexed shift
// register, commits 8 bytes into PID[47:0], BCR and DCR, and flags frame completion.
module daa_rx_deserializer (
    input  logic        i_deser_clk,
    input  logic        i_rst_n,
    input  logic        i_deser_en,
    input  logic        i_scl_pos_edge,
    input  logic        i_sda,
    input  logic [2:0]  i_cnt_bit_count,
    input  logic        i_cnt_done,
    output logic [47:0] o_pid,
    output logic [7:0]  o_bcr,
    output logic [7:0]  o_dcr,
    output logic        o_byte_valid,
    output logic [7:0]  o_byte,
    output logic [2:0]  o_byte_idx,
    output logic        o_deser_busy,
    output logic        o_deser_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_shift;
    logic [3:0]  r_byte_idx;
    logic [47:0] r_pid;
    logic [7:0]  r_bcr;
    logic [7:0]  r_dcr;
    logic        r_byte_valid;
    logic [7:0]  r_byte;
    logic [2:0]  r_byte_idx_out;
    logic        r_deser_done;

    logic        w_enter;
    logic        w_abort;
    logic        w_sample;
    logic        w_commit;
    logic        w_last;
    logic [7:0]  w_shift_next;

    // State register
    always_ff @(posedge i_deser_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        w_state_next = r_state;
        w_enter      = 1'b0;
        w_abort      = 1'b0;
        w_sample     = 1'b0;
        w_commit     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_deser_en) begin
                    w_state_next = ST_COLLECT;
                    w_enter      = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (!i_deser_en) begin
                    w_state_next = ST_IDLE;
                    w_abort      = 1'b1;
                end else begin
                    w_sample = i_scl_pos_edge;
                    w_commit = i_cnt_done;
                    w_last   = i_cnt_done && (r_byte_idx == 4'd7);
                    if (w_last) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!i_deser_en) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // A sample coinciding with a commit lands in the freshly cleared register
    always_comb begin
        w_shift_next = w_commit ? 8'h00 : r_shift;
        if (w_sample) begin
            w_shift_next[i_cnt_bit_count] = i_sda;
        end
    end

    // Shift register and byte index
    always_ff @(posedge i_deser_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift    <= 8'h00;
            r_byte_idx <= 4'd0;
        end else if (w_enter || w_abort) begin
            r_shift    <= 8'h00;
            r_byte_idx <= 4'd0;
        end else begin
            r_shift <= w_shift_next;
            if (w_commit) begin
                r_byte_idx <= r_byte_idx + 4'd1;
            end
        end
    end

    // Captured identity fields; partial bytes survive an abort until the next entry
    always_ff @(posedge i_deser_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pid <= 48'h0;
            r_bcr <= 8'h00;
            r_dcr <= 8'h00;
        end else if (w_enter) begin
            r_pid <= 48'h0;
            r_bcr <= 8'h00;
            r_dcr <= 8'h00;
        end else if (w_commit) begin
            for (int i = 0; i < 6; i++) begin
                if (r_byte_idx == 4'(i)) begin
                    r_pid[47-8*i -: 8] <= r_shift;
                end
            end
            if (r_byte_idx == 4'd6) begin
                r_bcr <= r_shift;
            end
            if (r_byte_idx == 4'd7) begin
                r_dcr <= r_shift;
            end
        end
    end

    // Byte stream outputs, one cycle after the commit strobe
    always_ff @(posedge i_deser_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_valid   <= 1'b0;
            r_byte         <= 8'h00;
            r_byte_idx_out <= 3'd0;
            r_deser_done   <= 1'b0;
        end else begin
            r_byte_valid <= w_commit;
            r_deser_done <= w_last;
            if (w_commit) begin
                r_byte         <= r_shift;
                r_byte_idx_out <= r_byte_idx[2:0];
            end
        end
    end

    assign o_pid        = r_pid;
    assign o_bcr        = r_bcr;
    assign o_dcr        = r_dcr;
    assign o_byte_valid = r_byte_valid;
    assign o_byte       = r_byte;
    assign o_byte_idx   = r_byte_idx_out;
    assign o_deser_done = r_deser_done;
    assign o_deser_busy = (r_state == ST_COLLECT);

endmodule

// File: tb/tb_daa_rx_deserializer.sv
// Scoreboard bench for daa_rx_deserializer: stimulus pushes expected committed bytes,
// a negedge monitor pops and compares them; field values are checked directly.
module tb_daa_rx_deserializer;

    logic        clk;
    logic        rst_n;
    logic        deser_en;
    logic        scl_pos_edge;
    logic        sda;
    logic [2:0]  cnt_bit_count;
    logic        cnt_done;
    logic [47:0] pid;
    logic [7:0]  bcr;
    logic [7:0]  dcr;
    logic        byte_valid;
    logic [7:0]  byte_out;
    logic [2:0]  byte_idx;
    logic        deser_busy;
    logic        deser_done;

    int n_checks = 0;
    int n_errors = 0;
    int n_done_seen = 0;
    logic [11:0] exp_q[$];

    daa_rx_deserializer dut (
        .i_deser_clk    (clk),
        .i_rst_n        (rst_n),
        .i_deser_en     (deser_en),
        .i_scl_pos_edge (scl_pos_edge),
        .i_sda          (sda),
        .i_cnt_bit_count(cnt_bit_count),
        .i_cnt_done     (cnt_done),
        .o_pid          (pid),
        .o_bcr          (bcr),
        .o_dcr          (dcr),
        .o_byte_valid   (byte_valid),
        .o_byte         (byte_out),
        .o_byte_idx     (byte_idx),
        .o_deser_busy   (deser_busy),
        .o_deser_done   (deser_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: every committed byte must match the head of the scoreboard
    always @(negedge clk) begin
        if (byte_valid) begin
            logic [11:0] e;
            if (deser_done) n_done_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_byte: got idx=%0d byte=0x%02h expected none", byte_idx, byte_out);
            end else begin
                e = exp_q.pop_front();
                check("byte_stream", {52'h0, deser_done, byte_idx, byte_out}, {52'h0, e});
            end
        end else if (deser_done) begin
            n_checks++;
            n_errors++;
            $display("FAIL stray_done: got done=1 without byte_valid expected 0");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int hi);
        for (int i = hi; i >= 0; i--) begin
            cnt_bit_count = 3'(i);
            sda           = b[i];
            scl_pos_edge  = 1'b1;
            tick();
            scl_pos_edge  = 1'b0;
            tick();
        end
    endtask

    task automatic commit(input logic [7:0] b, input int idx);
        exp_q.push_back({(idx == 7), 3'(idx), b});
        cnt_done = 1'b1;
        tick();
        cnt_done = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int idx);
        send_bits(b, 7);
        commit(b, idx);
    endtask

    task automatic send_frame(input logic [47:0] p, input logic [7:0] b, input logic [7:0] d);
        for (int k = 0; k < 6; k++) begin
            send_byte(p[47-8*k -: 8], k);
        end
        send_byte(b, 6);
        send_byte(d, 7);
    endtask

    task automatic check_fields(input string tag, input logic [47:0] p, input logic [7:0] b, input logic [7:0] d);
        check({tag, "_pid"}, {16'h0, pid}, {16'h0, p});
        check({tag, "_bcr"}, {56'h0, bcr}, {56'h0, b});
        check({tag, "_dcr"}, {56'h0, dcr}, {56'h0, d});
    endtask

    initial begin
        logic [47:0] hold_pid;
        logic [7:0]  hold_bcr, hold_dcr, hold_byte;

        rst_n = 1'b0; deser_en = 1'b0; scl_pos_edge = 1'b0; sda = 1'b0;
        cnt_bit_count = 3'd7; cnt_done = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {pid, byte_out, byte_idx, byte_valid, deser_busy, deser_done},
              64'h0);
        check_fields("reset", 48'h0, 8'h00, 8'h00);
        rst_n = 1'b1;
        tick();

        // Full frame
        deser_en = 1'b1;
        tick();
        check("busy_collect", {63'h0, deser_busy}, 64'h1);
        send_frame(48'h0123456789AB, 8'hC5, 8'h7E);
        tick();
        check_fields("full", 48'h0123456789AB, 8'hC5, 8'h7E);
        check("busy_in_done", {63'h0, deser_busy}, 64'h0);

        // DONE ignores further edges and commits
        send_bits(8'hFF, 7);
        cnt_done = 1'b1; tick(); cnt_done = 1'b0; tick();
        check_fields("done_hold", 48'h0123456789AB, 8'hC5, 8'h7E);
        deser_en = 1'b0;
        tick();
        check("busy_idle", {63'h0, deser_busy}, 64'h0);

        // Idle noise must not disturb anything
        hold_byte = byte_out;
        for (int i = 0; i < 24; i++) begin
            scl_pos_edge  = 1'($urandom_range(0, 1));
            sda           = 1'($urandom_range(0, 1));
            cnt_done      = 1'($urandom_range(0, 1));
            cnt_bit_count = 3'($urandom_range(0, 7));
            tick();
        end
        scl_pos_edge = 1'b0; cnt_done = 1'b0;
        tick();
        check_fields("idle_noise", 48'h0123456789AB, 8'hC5, 8'h7E);
        check("idle_noise_byte", {56'h0, byte_out}, {56'h0, hold_byte});
        check("idle_noise_busy", {63'h0, deser_busy}, 64'h0);

        // Abort after three bytes; partial fields remain visible
        deser_en = 1'b1;
        tick();
        check_fields("entry_clear", 48'h0, 8'h00, 8'h00);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 1);
        send_byte(8'hCC, 2);
        send_bits(8'h3C, 7);
        deser_en = 1'b0;
        tick(); tick();
        check("abort_busy", {63'h0, deser_busy}, 64'h0);
        check_fields("abort_partial", 48'hAABBCC000000, 8'h00, 8'h00);
        deser_en = 1'b1;
        tick();
        send_frame(48'h0123456789AB, 8'hC5, 8'h7E);
        tick();
        check_fields("after_abort", 48'h0123456789AB, 8'hC5, 8'h7E);
        deser_en = 1'b0;
        tick();

        // Coincident sample and commit: sample belongs to the next byte
        deser_en = 1'b1;
        tick();
        send_bits(8'h5A, 7);
        exp_q.push_back({1'b0, 3'd0, 8'h5A});
        cnt_done = 1'b1; scl_pos_edge = 1'b1; cnt_bit_count = 3'd7; sda = 1'b1;
        tick();
        cnt_done = 1'b0; scl_pos_edge = 1'b0;
        tick();
        send_bits(8'hB3, 6);
        commit(8'hB3, 1);
        tick();
        check("coincident_pid", {16'h0, pid}, {16'h0, 48'h5AB300000000});
        deser_en = 1'b0;
        tick();

        // Asynchronous reset in the middle of byte 4
        deser_en = 1'b1;
        tick();
        send_byte(8'h11, 0);
        send_byte(8'h22, 1);
        send_byte(8'h33, 2);
        send_byte(8'h44, 3);
        send_bits(8'h55, 7);
        rst_n = 1'b0;
        #2;
        check("async_reset_outputs",
              {pid, byte_out, byte_idx, byte_valid, deser_busy, deser_done}, 64'h0);
        check_fields("async_reset", 48'h0, 8'h00, 8'h00);
        deser_en = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        deser_en = 1'b1;
        tick();
        send_frame(48'hFEDCBA987654, 8'h3A, 8'h81);
        tick();
        check_fields("after_reset", 48'hFEDCBA987654, 8'h3A, 8'h81);
        deser_en = 1'b0;
        repeat (3) tick();

        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        check("done_pulses", 64'(n_done_seen), 64'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
